enc_speed_sched: RTL
====================

# enc_speed_sched

Windowed speed-sampling scheduler for the wheel-encoder counters. Every `GATE_CYCLES` clocks it snapshots all `NUM_ENC` free-running encoder counts and computes each channel's per-window delta with modulo-2^CNT_W arithmetic. It then serialises the deltas, channel by channel, over a valid/ready stream to the motor-control / comms logic. It sits between the per-motor encoder counters and the speed loop.

## Interface
- `NUM_ENC`, 4, number of encoder channels (≥2)
- `CNT_W`, 8, encoder counter width
- `GATE_CYCLES`, 50000, sample window length in `cka` cycles (≥4)
- `cka` in 1: single system clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `enable` in 1: run sampling windows
- `enc_count` in NUM_ENC*CNT_W: packed counts, channel i at bits [i*CNT_W +: CNT_W], synchronous to `cka`, up-counting with wrap
- `clr_ovr` in 1: clears `overrun`
- `out_valid` out 1: delta word available
- `out_ready` in 1: consumer accepts word
- `out_data` out CNT_W: delta count for `out_idx`
- `out_idx` out clog2(NUM_ENC): channel number of `out_data`
- `busy` out 1: high while in SEND
- `overrun` out 1: sticky, window lost due to backpressure

## Operation
- FSM states: IDLE, SEND.
- Gate timer:
  - Counts 0..GATE_CYCLES-1 while `enable`=1 and wraps to 0.
  - `tick` = (timer==GATE_CYCLES-1) & `enable`.
  - While `enable`=0, the timer is held at 0.
- Enable rising edge (registered `enable` 0→1): `prev[i]` ← `enc_count[i]` for all i, so the first window is clean.
- Tick in IDLE, or tick coinciding with the final accepted handshake in SEND:
  - For all i: `delta[i]` ← `enc_count[i]` − `prev[i]` (mod 2^CNT_W, unsigned) and `prev[i]` ← `enc_count[i]`.
  - FSM → SEND with idx=0.
- SEND:
  - `out_valid`=1, `out_data`=`delta[idx]`, `out_idx`=idx.
  - On `out_valid & out_ready`: idx+1.
  - After the transfer with idx=NUM_ENC-1 is accepted → IDLE, `out_valid`=0.
- Tick in SEND, other than on the final handshake:
  - `prev` is updated.
  - `delta` is not touched.
  - `overrun` ← 1.
- `overrun` clears only on `clr_ovr`=1. If `clr_ovr` and an overrun event occur in the same cycle, set wins.
- `enable` falling during SEND: the current burst completes and no new ticks are generated.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_idx`=0, `busy`=0, `overrun`=0.
  - timer=0, `prev`=0, `delta`=0, FSM=IDLE.
- Window: the first tick comes GATE_CYCLES cycles after `enable` is first sampled high.
- Latency: `out_valid` rises in the cycle after the tick edge.
- Handshake:
  - `out_data` and `out_idx` are stable while `out_valid & !out_ready`.
  - `out_valid` never drops without an accept.
  - One word per cycle maximum, so a full burst is NUM_ENC cycles with `out_ready` held high.
- Tick on the final accept: `out_valid` stays high and idx goes to 0 with new data in the next cycle.
- Async reset mid-SEND: all outputs go to their reset values immediately and the burst is discarded.

## Configuration
- `ENC_SCHED_SEQ_EN` defined:
  - Adds port `out_seq` (out, 8 bits), the window sequence number.
  - It increments on every tick that loads `delta` and wraps at 255.
  - It is constant for all words of one burst. Reset value is 0.
- `ENC_SCHED_SEQ_EN` undefined: the port and its counter are absent, and behaviour is otherwise identical.

## Structure
- Package `enc_sched_pkg`:
  - FSM state enum (IDLE, SEND).
  - Default parameter constants.
  - Index-width helper function.
- Sub-module `enc_gate_timer`:
  - Parameter GATE_CYCLES; inputs `cka`, `reset_n`, `enable`; output `tick`.
  - Also provides the registered enable rising-edge pulse.
- Top module holds the `prev`/`delta` arrays, the FSM and the output registers.

## Test plan
Test parameters: NUM_ENC=4, CNT_W=8, GATE_CYCLES=16.
- Reset asserted with random inputs → all outputs 0. Release, `enable`=0 for 100 cycles → `out_valid` never rises.
- `enable`=1; ch0 rises 10→15 within the window, ch1–3 constant → `out_valid` rises on cycle 17 after enable. Words with `out_ready`=1: (idx0,5),(idx1,0),(idx2,0),(idx3,0), then `busy`=0.
- Wrap: ch2 `prev`=250, count=4 at tick → (idx2, 10).
- Backpressure:
  - `out_ready`=0 for 3 cycles on idx1 → `out_data`/`out_idx` held.
  - `out_ready` held low across the next tick → `overrun`=1 and the remaining words of the old burst are still delivered.
  - `clr_ovr` pulse → `overrun`=0.
- Tick on the cycle idx3 is accepted → `overrun` stays 0 and `out_valid` is continuous with idx0 of the new window next cycle.
- `reset_n` low mid-burst at idx2 → outputs 0 immediately. After release plus `enable`, the first window delta is relative to the counts at enable.

Source files
------------

// File: rtl/enc_sched_pkg.sv
// Shared types, default parameters and helpers for the encoder speed scheduler.
package enc_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sched_state_e;

    localparam int DEF_NUM_ENC     = 4;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_GATE_CYCLES = 50000;

    // Channel index width; never below one bit so out_idx always exists.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/enc_gate_timer.sv
// Sample-window gate timer: emits tick on the last cycle of each GATE_CYCLES window
// and a pulse on the first cycle enable is sampled high.
module enc_gate_timer
    import enc_sched_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES
) (
    input  logic cka,
    input  logic reset_n,
    input  logic enable,
    output logic tick,
    output logic en_rise
);

    localparam int TW = $clog2(GATE_CYCLES);

    logic [TW-1:0] timer_q, timer_d;
    logic          enable_q;

    // The timer stays at 0 on the enable rising edge so that the first
    // window spans exactly GATE_CYCLES cycles from the prev snapshot.
    always_comb begin
        en_rise = enable & ~enable_q;
        tick    = enable && (timer_q == TW'(GATE_CYCLES - 1));
        timer_d = '0;
        if (enable && enable_q && !tick) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge cka or negedge reset_n) begin
        if (!reset_n) begin
            timer_q  <= '0;
            enable_q <= 1'b0;
        end else begin
            timer_q  <= timer_d;
            enable_q <= enable;
        end
    end

endmodule

// File: rtl/enc_speed_sched.sv
// Windowed speed sampler: snapshots all encoder counts each window and streams the deltas.
// Optional macro ENC_SCHED_SEQ_EN adds the 8-bit window sequence number output out_seq.
module enc_speed_sched
    import enc_sched_pkg::*;
#(
    parameter int  NUM_ENC     = DEF_NUM_ENC,
    parameter int  CNT_W       = DEF_CNT_W,
    parameter int  GATE_CYCLES = DEF_GATE_CYCLES,
    localparam int IDX_W       = idx_width(NUM_ENC)
) (
    input  logic                     cka,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [NUM_ENC*CNT_W-1:0] enc_count,
    input  logic                     clr_ovr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     busy,
    output logic                     overrun
`ifdef ENC_SCHED_SEQ_EN
    ,
    output logic [7:0]               out_seq
`endif
);

    logic tick, en_rise;

    enc_gate_timer #(
        .GATE_CYCLES(GATE_CYCLES)
    ) u_gate_timer (
        .cka    (cka),
        .reset_n(reset_n),
        .enable (enable),
        .tick   (tick),
        .en_rise(en_rise)
    );

    logic [CNT_W-1:0] cnt_ch [NUM_ENC];

    generate
        for (genvar gi = 0; gi < NUM_ENC; gi++) begin : g_ch
            assign cnt_ch[gi] = enc_count[gi*CNT_W +: CNT_W];
        end
    endgenerate

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] prev_q  [NUM_ENC];
    logic [CNT_W-1:0] prev_d  [NUM_ENC];
    logic [CNT_W-1:0] delta_q [NUM_ENC];
    logic [CNT_W-1:0] delta_d [NUM_ENC];
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             accept, last_acc, load;

`ifdef ENC_SCHED_SEQ_EN
    logic [7:0] seq_q, seq_d;
`endif

    always_comb begin
        accept   = (state_q == SEND) && out_ready;
        last_acc = accept && (idx_q == IDX_W'(NUM_ENC - 1));
        // A tick landing on the final accept chains straight into the next burst.
        load     = tick && ((state_q == IDLE) || last_acc);

        state_d = state_q;
        idx_d   = idx_q;
        for (int i = 0; i < NUM_ENC; i++) begin
            prev_d[i]  = (tick || en_rise) ? cnt_ch[i] : prev_q[i];
            delta_d[i] = load ? (cnt_ch[i] - prev_q[i]) : delta_q[i];
        end

        if (load) begin
            state_d = SEND;
            idx_d   = '0;
        end else if (accept) begin
            if (last_acc) begin
                state_d = IDLE;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        overrun_d = overrun_q & ~clr_ovr;
        if (tick && (state_q == SEND) && !last_acc) begin
            overrun_d = 1'b1;
        end

        out_valid_d = (state_d == SEND);
        busy_d      = (state_d == SEND);
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        if (state_d == SEND) begin
            out_idx_d  = idx_d;
            out_data_d = delta_d[idx_d];
        end

`ifdef ENC_SCHED_SEQ_EN
        seq_d = load ? seq_q + 8'd1 : seq_q;
`endif
    end

    always_ff @(posedge cka or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < NUM_ENC; i++) begin
                prev_q[i]  <= '0;
                delta_q[i] <= '0;
            end
`ifdef ENC_SCHED_SEQ_EN
            seq_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            for (int i = 0; i < NUM_ENC; i++) begin
                prev_q[i]  <= prev_d[i];
                delta_q[i] <= delta_d[i];
            end
`ifdef ENC_SCHED_SEQ_EN
            seq_q       <= seq_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
`ifdef ENC_SCHED_SEQ_EN
    assign out_seq   = seq_q;
`endif

endmodule
